// File: rtl/mdu_pkg.sv
// Shared constants, types and helpers for the sequential multiply/divide unit.
// Holds the R-type funct codes, the controller state enum, the iteration
// count and the packed HI/LO result payload.
package mdu_pkg;

    localparam int unsigned XLEN       = 32;
    localparam int unsigned ITER_COUNT = 32;
    localparam int unsigned CNT_W      = $clog2(ITER_COUNT);

    localparam logic [5:0] FN_MTHI  = 6'h11;
    localparam logic [5:0] FN_MTLO  = 6'h13;
    localparam logic [5:0] FN_MULT  = 6'h18;
    localparam logic [5:0] FN_MULTU = 6'h19;
    localparam logic [5:0] FN_DIV   = 6'h1a;
    localparam logic [5:0] FN_DIVU  = 6'h1b;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ITER = 2'd1,
        ST_FIX  = 2'd2
    } state_e;

    // HI/LO result pair as one 64-bit payload.
    typedef struct packed {
        logic [XLEN-1:0] hi;
        logic [XLEN-1:0] lo;
    } hilo_t;

    // Two's-complement negate when neg is set.
    function automatic logic [XLEN-1:0] cond_neg(input logic [XLEN-1:0] x,
                                                 input logic            neg);
        return neg ? XLEN'(~x + XLEN'(1)) : x;
    endfunction

    // Absolute value for signed operations, pass-through for unsigned ones.
    function automatic logic [XLEN-1:0] magnitude(input logic [XLEN-1:0] x,
                                                  input logic            is_signed);
        return cond_neg(x, is_signed & x[XLEN-1]);
    endfunction

endpackage

// File: rtl/mdu_addsub.sv
// Shared W-bit adder/subtractor used by the multiply (add) and divide
// (trial subtract) iteration steps.
// Ports:
//   a_i, b_i  operands
//   sub_i     1: a_i - b_i, 0: a_i + b_i
//   sum_c_o   W-bit result (combinational)
//   cout_c_o  carry out; on subtract 1 means a_i >= b_i (no borrow)
module mdu_addsub #(
    parameter int unsigned W = 33
) (
    input  logic [W-1:0] a_i,
    input  logic [W-1:0] b_i,
    input  logic         sub_i,
    output logic [W-1:0] sum_c_o,
    output logic         cout_c_o
);

    logic [W-1:0] b_eff;

    assign b_eff = sub_i ? ~b_i : b_i;
    assign {cout_c_o, sum_c_o} = {1'b0, a_i} + {1'b0, b_eff} + (W + 1)'(sub_i);

endmodule

// File: rtl/mdu_seq.sv
// Sequential HI/LO multiply/divide unit: radix-2, one step per cycle,
// 34-cycle latency from the accepting edge to the done pulse.
// Ports:
//   clk, rst_n   rising-edge clock, asynchronous active-low reset
//   start        request strobe, only honoured while idle
//   funct        MULT/MULTU/DIV/DIVU start an operation, MTHI/MTLO write hi/lo
//   a, b         rs / rt operands, sampled only at the accepting edge
//   busy         high while an operation is in flight
//   done         one-cycle pulse when hi/lo take the new result
//   hi, lo       architectural HI/LO registers
// Build option: define MDU_DIV_EN to include the divide datapath; without it
// DIV/DIVU requests are ignored like any unknown funct.
module mdu_seq
    import mdu_pkg::*;
#(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [5:0]       funct,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(ITER_COUNT - 1);

    state_e           state_q, state_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic [WIDTH-1:0] p_hi_q, p_hi_d;   // partial product high / remainder
    logic [WIDTH-1:0] p_lo_q, p_lo_d;   // multiplier bits / dividend-quotient
    logic [WIDTH-1:0] m_q, m_d;         // multiplicand or divisor magnitude
    logic             neg_q, neg_d;     // negate product / quotient in FIX
    logic [WIDTH-1:0] hi_q, hi_d;
    logic [WIDTH-1:0] lo_q, lo_d;
    logic             done_q, done_d;
    logic             busy_q;
    logic             accept;
    logic             op_signed;

    logic [WIDTH:0]   as_a, as_b, as_sum;
    logic             as_sub, as_cout;
    hilo_t            prod_fix;

`ifdef MDU_DIV_EN
    logic             is_div_q, is_div_d;
    logic             rneg_q, rneg_d;   // remainder takes the dividend's sign
    logic             op_div;
`else
    logic             unused_cout;
`endif

    // Adder operands come from registers only, so the step logic never loops.
`ifdef MDU_DIV_EN
    assign as_sub = is_div_q;
    assign as_a   = is_div_q ? {p_hi_q, p_lo_q[WIDTH-1]} : {1'b0, p_hi_q};
`else
    assign as_sub      = 1'b0;
    assign as_a        = {1'b0, p_hi_q};
    assign unused_cout = as_cout;
`endif
    assign as_b = {1'b0, m_q};

    mdu_addsub #(
        .W (WIDTH + 1)
    ) u_addsub (
        .a_i      (as_a),
        .b_i      (as_b),
        .sub_i    (as_sub),
        .sum_c_o  (as_sum),
        .cout_c_o (as_cout)
    );

    // Signed multiply correction negates the whole 64-bit product.
    assign prod_fix = hilo_t'(neg_q ? (~{p_hi_q, p_lo_q} + (2 * XLEN)'(1))
                                    : {p_hi_q, p_lo_q});

    // Next-state and datapath update.
    always_comb begin
        state_d   = state_q;
        count_d   = count_q;
        p_hi_d    = p_hi_q;
        p_lo_d    = p_lo_q;
        m_d       = m_q;
        neg_d     = neg_q;
        hi_d      = hi_q;
        lo_d      = lo_q;
        done_d    = 1'b0;
        accept    = 1'b0;
        op_signed = 1'b0;
`ifdef MDU_DIV_EN
        is_div_d  = is_div_q;
        rneg_d    = rneg_q;
        op_div    = 1'b0;
`endif

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    case (funct)
                        FN_MULT: begin
                            accept    = 1'b1;
                            op_signed = 1'b1;
                        end
                        FN_MULTU: accept = 1'b1;
`ifdef MDU_DIV_EN
                        FN_DIV: begin
                            accept    = 1'b1;
                            op_signed = 1'b1;
                            op_div    = 1'b1;
                        end
                        FN_DIVU: begin
                            accept = 1'b1;
                            op_div = 1'b1;
                        end
`endif
                        FN_MTHI: hi_d = a;
                        FN_MTLO: lo_d = a;
                        default: ;
                    endcase
                end
                if (accept) begin
                    state_d = ST_ITER;
                    count_d = '0;
                    p_hi_d  = '0;
                    p_lo_d  = magnitude(a, op_signed);
                    m_d     = magnitude(b, op_signed);
                    // A zero divisor must leave the all-ones quotient unsigned.
                    neg_d   = op_signed & (a[WIDTH-1] ^ b[WIDTH-1]) & (|b);
`ifdef MDU_DIV_EN
                    is_div_d = op_div;
                    rneg_d   = op_signed & a[WIDTH-1];
`endif
                end
            end

            ST_ITER: begin
`ifdef MDU_DIV_EN
                if (is_div_q) begin
                    // Restoring step: keep the difference only when no borrow.
                    p_hi_d = as_cout ? as_sum[WIDTH-1:0] : as_a[WIDTH-1:0];
                    p_lo_d = {p_lo_q[WIDTH-2:0], as_cout};
                end else
`endif
                begin
                    // Shift-add step: conditional add, then shift {hi,lo} right.
                    if (p_lo_q[0]) begin
                        {p_hi_d, p_lo_d} = {as_sum, p_lo_q[WIDTH-1:1]};
                    end else begin
                        {p_hi_d, p_lo_d} = {1'b0, p_hi_q, p_lo_q[WIDTH-1:1]};
                    end
                end
                count_d = count_q + CNT_W'(1);
                if (count_q == LAST_CNT) begin
                    state_d = ST_FIX;
                end
            end

            ST_FIX: begin
`ifdef MDU_DIV_EN
                if (is_div_q) begin
                    lo_d = cond_neg(p_lo_q, neg_q);
                    hi_d = cond_neg(p_hi_q, rneg_q);
                end else
`endif
                begin
                    hi_d = prod_fix.hi;
                    lo_d = prod_fix.lo;
                end
                state_d = ST_IDLE;
                done_d  = 1'b1;
            end

            default: state_d = ST_IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Datapath and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q  <= '0;
            p_hi_q   <= '0;
            p_lo_q   <= '0;
            m_q      <= '0;
            neg_q    <= 1'b0;
            hi_q     <= '0;
            lo_q     <= '0;
            done_q   <= 1'b0;
            busy_q   <= 1'b0;
`ifdef MDU_DIV_EN
            is_div_q <= 1'b0;
            rneg_q   <= 1'b0;
`endif
        end else begin
            count_q  <= count_d;
            p_hi_q   <= p_hi_d;
            p_lo_q   <= p_lo_d;
            m_q      <= m_d;
            neg_q    <= neg_d;
            hi_q     <= hi_d;
            lo_q     <= lo_d;
            done_q   <= done_d;
            busy_q   <= (state_d != ST_IDLE);
`ifdef MDU_DIV_EN
            is_div_q <= is_div_d;
            rneg_q   <= rneg_d;
`endif
        end
    end

    assign busy = busy_q;
    assign done = done_q;
    assign hi   = hi_q;
    assign lo   = lo_q;

endmodule

// File: tb/tb_mdu_seq.sv
// Self-checking bench for mdu_seq: scoreboard of expected HI/LO results,
// latency/busy profile checks, move/ignore behaviour, back-to-back issue and
// mid-operation reset. Honours MDU_DIV_EN the same way the design does.
`timescale 1ns/1ps
module tb_mdu_seq;
    import mdu_pkg::*;

    localparam int TIMEOUT = 60;

    logic        clk   = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [5:0]  funct = 6'h3f;
    logic [31:0] a     = '0;
    logic [31:0] b     = '0;
    logic        busy, done;
    logic [31:0] hi, lo;

    int    checks = 0;
    int    errors = 0;
    hilo_t sb[$];

    mdu_seq #(.WIDTH(32)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .funct (funct),
        .a     (a),
        .b     (b),
        .busy  (busy),
        .done  (done),
        .hi    (hi),
        .lo    (lo)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog expired");
    end

    // Reference result computed with language arithmetic.
    function automatic hilo_t model(input logic [5:0] f, input logic [31:0] x,
                                    input logic [31:0] y);
        hilo_t  r;
        longint sx, sy;
        int     qs, rs;
        r = '0;
        case (f)
            FN_MULT: begin
                sx = longint'($signed(x));
                sy = longint'($signed(y));
                {r.hi, r.lo} = sx * sy;
            end
            FN_MULTU: {r.hi, r.lo} = {32'd0, x} * {32'd0, y};
            FN_DIV: begin
                if (y == 32'd0) begin
                    r.hi = x;
                    r.lo = 32'hFFFF_FFFF;
                end else if (x == 32'h8000_0000 && y == 32'hFFFF_FFFF) begin
                    r.hi = 32'd0;
                    r.lo = 32'h8000_0000;
                end else begin
                    qs   = $signed(x) / $signed(y);
                    rs   = $signed(x) % $signed(y);
                    r.lo = qs;
                    r.hi = rs;
                end
            end
            FN_DIVU: begin
                if (y == 32'd0) begin
                    r.hi = x;
                    r.lo = 32'hFFFF_FFFF;
                end else begin
                    r.lo = x / y;
                    r.hi = x % y;
                end
            end
            default: r = '0;
        endcase
        return r;
    endfunction

    // Present one request for exactly one edge, then scramble the operands.
    task automatic issue(input bit sync, input logic [5:0] f,
                         input logic [31:0] x, input logic [31:0] y);
        if (sync) @(negedge clk);
        start = 1'b1;
        funct = f;
        a     = x;
        b     = y;
        @(posedge clk);
        #1;
        start = 1'b0;
        funct = 6'h3f;
        a     = $urandom;
        b     = $urandom;
    endtask

    // Bounded wait for done; lat=0 means it never came. Optionally injects an
    // MTLO request while the unit is busy.
    task automatic wait_done(input int inject_at, output int lat, output int nbusy,
                             output bit busy_at_done, output bit hl_moved);
        logic [31:0] hi0, lo0;
        hi0 = hi;
        lo0 = lo;
        lat = 0;
        nbusy = 0;
        busy_at_done = 1'b0;
        hl_moved = 1'b0;
        for (int k = 1; k <= TIMEOUT; k++) begin
            @(negedge clk);
            if (done) begin
                lat = k;
                busy_at_done = busy;
                return;
            end
            if (busy) nbusy++;
            if (hi !== hi0 || lo !== lo0) hl_moved = 1'b1;
            if (k == inject_at) begin
                start = 1'b1;
                funct = FN_MTLO;
                a     = 32'h1234;
            end else if (k == inject_at + 1) begin
                start = 1'b0;
            end
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        start = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", busy); end
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b expected 0", done); end
        checks++; if (hi !== 32'd0) begin errors++; $display("FAIL reset_hi: got %h expected 0", hi); end
        checks++; if (lo !== 32'd0) begin errors++; $display("FAIL reset_lo: got %h expected 0", lo); end
        rst_n = 1'b1;
    endtask

    task automatic test_mult();
        logic [5:0]  fs [8];
        logic [31:0] xs [8];
        logic [31:0] ys [8];
        hilo_t e, got;
        int lat, nb;
        bit bd, hm;
        fs = '{FN_MULTU, FN_MULT, FN_MULT, FN_MULT, FN_MULT, FN_MULTU, FN_MULT, FN_MULTU};
        xs = '{32'hFFFF_FFFF, 32'hFFFF_FFF9, 32'h8000_0000, 32'h8000_0000,
               32'h7FFF_FFFF, 32'd0, $urandom, $urandom};
        ys = '{32'hFFFF_FFFF, 32'd3, 32'h8000_0000, 32'hFFFF_FFFF,
               32'h8000_0000, $urandom, $urandom, $urandom};
        for (int i = 0; i < 8; i++) begin
            e = model(fs[i], xs[i], ys[i]);
            if (i == 0) e = hilo_t'(64'hFFFF_FFFE_0000_0001);
            if (i == 1) e = hilo_t'(64'hFFFF_FFFF_FFFF_FFEB);
            // The first request lands on the first edge after reset release.
            issue(i != 0, fs[i], xs[i], ys[i]);
            sb.push_back(e);
            wait_done(0, lat, nb, bd, hm);
            got = sb.pop_front();
            checks++; if (lat !== 34) begin errors++; $display("FAIL mult_latency[%0d]: got %0d expected 34", i, lat); end
            checks++; if (nb !== 33) begin errors++; $display("FAIL mult_busy_cycles[%0d]: got %0d expected 33", i, nb); end
            checks++; if (bd !== 1'b0) begin errors++; $display("FAIL mult_busy_at_done[%0d]: got %b expected 0", i, bd); end
            checks++; if (hm !== 1'b0) begin errors++; $display("FAIL mult_early_write[%0d]: got %b expected 0", i, hm); end
            checks++; if (hi !== got.hi) begin errors++; $display("FAIL mult_hi[%0d]: got %h expected %h", i, hi, got.hi); end
            checks++; if (lo !== got.lo) begin errors++; $display("FAIL mult_lo[%0d]: got %h expected %h", i, lo, got.lo); end
        end
    endtask

    task automatic test_move();
        issue(1'b1, FN_MTHI, 32'hA5A5_0F0F, 32'h0);
        checks++; if (hi !== 32'hA5A5_0F0F) begin errors++; $display("FAIL mthi_hi: got %h expected a5a50f0f", hi); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL mthi_busy: got %b expected 0", busy); end
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL mthi_done: got %b expected 0", done); end
        issue(1'b1, FN_MTLO, 32'h5A5A_F0F0, 32'h0);
        checks++; if (lo !== 32'h5A5A_F0F0) begin errors++; $display("FAIL mtlo_lo: got %h expected 5a5af0f0", lo); end
        checks++; if (hi !== 32'hA5A5_0F0F) begin errors++; $display("FAIL mtlo_hi_kept: got %h expected a5a50f0f", hi); end
        @(negedge clk);
        checks++; if (busy !== 1'b0 || done !== 1'b0) begin errors++; $display("FAIL mtlo_quiet: got busy=%b done=%b expected 0 0", busy, done); end
    endtask

    task automatic test_ignored();
        logic [5:0]  fn [3];
        logic [31:0] hi0, lo0;
        int nb, nd;
        fn = '{6'h20, 6'h10, 6'h12};
        hi0 = hi;
        lo0 = lo;
        nb = 0;
        nd = 0;
        for (int i = 0; i < 3; i++) begin
            issue(1'b1, fn[i], 32'h1357_9BDF, 32'h2468_ACE0);
            for (int k = 0; k < 5; k++) begin
                @(negedge clk);
                if (busy) nb++;
                if (done) nd++;
            end
        end
        checks++; if (nb !== 0) begin errors++; $display("FAIL ignored_busy: got %0d busy cycles expected 0", nb); end
        checks++; if (nd !== 0) begin errors++; $display("FAIL ignored_done: got %0d done pulses expected 0", nd); end
        checks++; if (hi !== hi0) begin errors++; $display("FAIL ignored_hi: got %h expected %h", hi, hi0); end
        checks++; if (lo !== lo0) begin errors++; $display("FAIL ignored_lo: got %h expected %h", lo, lo0); end
    endtask

    task automatic test_back_to_back();
        hilo_t got;
        int lat, nb;
        bit bd, hm;
        issue(1'b1, FN_MULT, 32'd5, 32'd6);
        sb.push_back(hilo_t'({32'd0, 32'd30}));
        wait_done(10, lat, nb, bd, hm);
        got = sb.pop_front();
        checks++; if (lat !== 34) begin errors++; $display("FAIL b2b_first_latency: got %0d expected 34", lat); end
        checks++; if (hm !== 1'b0) begin errors++; $display("FAIL b2b_busy_mtlo_ignored: got %b expected 0", hm); end
        checks++; if (hi !== got.hi || lo !== got.lo) begin errors++; $display("FAIL b2b_first_result: got %h_%h expected %h_%h", hi, lo, got.hi, got.lo); end
        // Issue in the done cycle itself.
`ifdef MDU_DIV_EN
        issue(1'b0, FN_DIVU, 32'd100, 32'd7);
        sb.push_back(hilo_t'({32'd2, 32'd14}));
`else
        issue(1'b0, FN_MULTU, 32'h0001_0000, 32'h0001_0003);
        sb.push_back(hilo_t'({32'd1, 32'h0003_0000}));
`endif
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL b2b_second_accepted: got busy=%b expected 1", busy); end
        wait_done(0, lat, nb, bd, hm);
        got = sb.pop_front();
        checks++; if (lat !== 34) begin errors++; $display("FAIL b2b_second_latency: got %0d expected 34", lat); end
        checks++; if (hi !== got.hi || lo !== got.lo) begin errors++; $display("FAIL b2b_second_result: got %h_%h expected %h_%h", hi, lo, got.hi, got.lo); end
    endtask

`ifdef MDU_DIV_EN
    task automatic test_div();
        logic [5:0]  fs [9];
        logic [31:0] xs [9];
        logic [31:0] ys [9];
        hilo_t e, got;
        int lat, nb;
        bit bd, hm;
        fs = '{FN_DIV, FN_DIVU, FN_DIV, FN_DIV, FN_DIV, FN_DIVU, FN_DIV, FN_DIV, FN_DIVU};
        xs = '{32'hFFFF_FFF9, 32'd7, 32'h8000_0000, 32'hFFFF_FFF9, 32'd7,
               32'hFFFF_FFFF, $urandom, $urandom, $urandom};
        ys = '{32'd2, 32'd0, 32'hFFFF_FFFF, 32'd0, 32'hFFFF_FFFE,
               32'd3, $urandom, 32'hFFFF_FF00 | 32'($urandom_range(255, 1)), $urandom_range(65535, 1)};
        for (int i = 0; i < 9; i++) begin
            e = model(fs[i], xs[i], ys[i]);
            if (i == 0) e = hilo_t'(64'hFFFF_FFFF_FFFF_FFFD);
            if (i == 1) e = hilo_t'(64'h0000_0007_FFFF_FFFF);
            if (i == 2) e = hilo_t'(64'h0000_0000_8000_0000);
            if (i == 3) e = hilo_t'(64'hFFFF_FFF9_FFFF_FFFF);
            issue(1'b1, fs[i], xs[i], ys[i]);
            sb.push_back(e);
            wait_done(0, lat, nb, bd, hm);
            got = sb.pop_front();
            checks++; if (lat !== 34) begin errors++; $display("FAIL div_latency[%0d]: got %0d expected 34", i, lat); end
            checks++; if (nb !== 33) begin errors++; $display("FAIL div_busy_cycles[%0d]: got %0d expected 33", i, nb); end
            checks++; if (hm !== 1'b0) begin errors++; $display("FAIL div_early_write[%0d]: got %b expected 0", i, hm); end
            checks++; if (hi !== got.hi) begin errors++; $display("FAIL div_hi[%0d]: got %h expected %h", i, hi, got.hi); end
            checks++; if (lo !== got.lo) begin errors++; $display("FAIL div_lo[%0d]: got %h expected %h", i, lo, got.lo); end
        end
    endtask
`else
    task automatic test_div_disabled();
        logic [31:0] hi0, lo0;
        int nb, nd;
        hi0 = hi;
        lo0 = lo;
        nb = 0;
        nd = 0;
        issue(1'b1, FN_DIV, 32'd100, 32'd7);
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (busy) nb++;
            if (done) nd++;
        end
        issue(1'b1, FN_DIVU, 32'd100, 32'd0);
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (busy) nb++;
            if (done) nd++;
        end
        checks++; if (nb !== 0) begin errors++; $display("FAIL nodiv_busy: got %0d busy cycles expected 0", nb); end
        checks++; if (nd !== 0) begin errors++; $display("FAIL nodiv_done: got %0d done pulses expected 0", nd); end
        checks++; if (hi !== hi0) begin errors++; $display("FAIL nodiv_hi: got %h expected %h", hi, hi0); end
        checks++; if (lo !== lo0) begin errors++; $display("FAIL nodiv_lo: got %h expected %h", lo, lo0); end
    endtask
`endif

    task automatic test_reset_mid();
        int nb, nd;
        issue(1'b1, FN_MTHI, 32'hDEAD_BEEF, 32'h0);
        issue(1'b1, FN_MTLO, 32'hCAFE_F00D, 32'h0);
        issue(1'b1, FN_MULT, 32'h0001_2345, 32'h0000_6789);
        for (int k = 1; k <= 20; k++) @(negedge clk);
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL midrst_busy_before: got %b expected 1", busy); end
        rst_n = 1'b0;
        #1;
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL midrst_busy: got %b expected 0", busy); end
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL midrst_done: got %b expected 0", done); end
        checks++; if (hi !== 32'd0) begin errors++; $display("FAIL midrst_hi: got %h expected 0", hi); end
        checks++; if (lo !== 32'd0) begin errors++; $display("FAIL midrst_lo: got %h expected 0", lo); end
        @(negedge clk);
        rst_n = 1'b1;
        nb = 0;
        nd = 0;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (busy) nb++;
            if (done) nd++;
        end
        checks++; if (nd !== 0) begin errors++; $display("FAIL midrst_no_done: got %0d done pulses expected 0", nd); end
        checks++; if (nb !== 0) begin errors++; $display("FAIL midrst_no_busy: got %0d busy cycles expected 0", nb); end
        checks++; if (hi !== 32'd0 || lo !== 32'd0) begin errors++; $display("FAIL midrst_hilo_after: got %h_%h expected 0_0", hi, lo); end
    endtask

    initial begin
        test_reset();
        test_mult();
        test_move();
        test_ignored();
        test_back_to_back();
`ifdef MDU_DIV_EN
        test_div();
`else
        test_div_disabled();
`endif
        test_reset_mid();
        checks++; if (sb.size() !== 0) begin errors++; $display("FAIL scoreboard_drain: got %0d entries expected 0", sb.size()); end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
